key_event_ctrl: RTL and testbench



---
 rtl/key_event_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Key gesture controller: classifies debounced key activity into SHORT, LONG and
// DOUBLE events and queues them round-robin into a small valid/ready event FIFO.
module key_event_ctrl #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned LONG_CNT   = 50000000,
  parameter int unsigned DCLICK_CNT = 15000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_flag,
  input  logic [N_KEYS-1:0] key_value,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2:0]        evt_key,
  output logic [1:0]        evt_code,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int unsigned KIW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LONG_LAST   = 32'(LONG_CNT - 1);
  localparam logic [31:0] DCLICK_LAST = 32'(DCLICK_CNT - 1);
  localparam logic [1:0]  CODE_SHORT  = 2'b01;
  localparam logic [1:0]  CODE_LONG   = 2'b10;
  localparam logic [1:0]  CODE_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESSED = 3'd1,
    S_HELD    = 3'd2,
    S_WAIT2   = 3'd3,
    S_PRESS2  = 3'd4
  } state_e;

  state_e            st_q        [N_KEYS];
  logic [31:0]       cnt_q       [N_KEYS];
  logic [1:0]        code_q      [N_KEYS];
  logic [1:0]        emit_code_c [N_KEYS];
  logic [N_KEYS-1:0] pend_q;
  logic [N_KEYS-1:0] press_c;
  logic [N_KEYS-1:0] rel_c;
  logic [N_KEYS-1:0] emit_c;
  logic [N_KEYS-1:0] grant_c;
  logic [N_KEYS-1:0] drop_c;
  logic [KIW-1:0]    rr_q;
  logic [KIW-1:0]    gnt_idx_c;
  logic              push_c;
  logic              pop_c;
  logic [4:0]        push_data_c;
  logic [4:0]        fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [4:0]        head_q;
  logic [4:0]        head_d;
  logic              valid_q;
  logic              ovf_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign press_c = key_flag & ~key_value;
  assign rel_c   = key_flag & key_value;

  // Event decode: the transitions that produce an event, with release/press priority
  always_comb begin
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      emit_c[i]      = 1'b0;
      emit_code_c[i] = 2'b00;
      case (st_q[i])
        S_PRESSED: if (!rel_c[i] && cnt_q[i] == LONG_LAST) begin
          emit_c[i]      = 1'b1;
          emit_code_c[i] = CODE_LONG;
        end
        S_WAIT2: if (!press_c[i] && cnt_q[i] == DCLICK_LAST) begin
          emit_c[i]      = 1'b1;
          emit_code_c[i] = CODE_SHORT;
        end
        S_PRESS2: if (rel_c[i]) begin
          emit_c[i]      = 1'b1;
          emit_code_c[i] = CODE_DOUBLE;
        end
        default: ;
      endcase
    end
  end

  // Per-key gesture FSMs; cnt is cleared on every state entry
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        case (st_q[i])
          S_IDLE: if (press_c[i]) begin
            st_q[i]  <= S_PRESSED;
            cnt_q[i] <= '0;
          end
          S_PRESSED: begin
            if (rel_c[i]) begin
              st_q[i]  <= S_WAIT2;
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == LONG_LAST) begin
              st_q[i]  <= S_HELD;
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= sat_inc(cnt_q[i]);
            end
          end
          S_HELD: if (rel_c[i]) begin
            st_q[i]  <= S_IDLE;
            cnt_q[i] <= '0;
          end
          S_WAIT2: begin
            if (press_c[i]) begin
              st_q[i]  <= S_PRESS2;
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == DCLICK_LAST) begin
              st_q[i]  <= S_IDLE;
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= sat_inc(cnt_q[i]);
            end
          end
          S_PRESS2: if (rel_c[i]) begin
            st_q[i]  <= S_IDLE;
            cnt_q[i] <= '0;
          end
          default: begin
            st_q[i]  <= S_IDLE;
            cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  // Round-robin search starting at the key after the last grant; full test uses registered count
  always_comb begin
    logic [3:0] idx;
    idx       = '0;
    push_c    = 1'b0;
    grant_c   = '0;
    gnt_idx_c = '0;
    if (count_q < CW'(FIFO_DEPTH)) begin
      for (int unsigned off = 0; off < N_KEYS; off++) begin
        idx = 4'(rr_q) + 4'(off);
        if (idx >= 4'(N_KEYS)) idx = idx - 4'(N_KEYS);
        if (!push_c && pend_q[KIW'(idx)]) begin
          push_c               = 1'b1;
          grant_c[KIW'(idx)]   = 1'b1;
          gnt_idx_c            = KIW'(idx);
        end
      end
    end
  end

  assign push_data_c = {3'(gnt_idx_c), code_q[gnt_idx_c]};
  assign drop_c      = emit_c & pend_q & ~grant_c;

  // Pending slots: a grant frees the slot in the same cycle a new emit may refill it
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      rr_q   <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) code_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (emit_c[i] && !drop_c[i]) begin
          pend_q[i] <= 1'b1;
          code_q[i] <= emit_code_c[i];
        end else if (grant_c[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (|drop_c)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (push_c) rr_q <= (gnt_idx_c == KIW'(N_KEYS - 1)) ? '0 : gnt_idx_c + 1'b1;
    end
  end

  assign pop_c   = valid_q & evt_ready;
  assign count_d = count_q + CW'(push_c) - CW'(pop_c);

  // Registered head: next head is the following entry on pop, or the pushed entry when it lands first
  always_comb begin
    head_d = head_q;
    if (pop_c) begin
      if (count_q > CW'(1))  head_d = fifo_mem_q[rd_ptr_q + AW'(1)];
      else if (push_c)       head_d = push_data_c;
    end else if (count_q == '0 && push_c) begin
      head_d = push_data_c;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_c) fifo_mem_q[wr_ptr_q] <= push_data_c;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      head_q  <= head_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_key   = head_q[4:2];
  assign evt_code  = head_q[1:0];
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: timestamp-based gesture model plus arbiter/FIFO occupancy
// model feeding a scoreboard queue; a negedge monitor checks every handshake.
module tb_key_event_ctrl;

  localparam int NK = 4;
  localparam int LC = 20;
  localparam int DC = 10;
  localparam int FD = 4;

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b1;
  logic [3:0]  key_flag  = '0;
  logic [3:0]  key_value = '1;
  logic        evt_ready = 1'b0;
  logic        ovf_clr   = 1'b0;
  logic        evt_valid;
  logic        evt_ovf;
  logic [2:0]  evt_key;
  logic [1:0]  evt_code;

  int          total = 0;
  int          bad   = 0;
  logic [4:0]  sb  [$];
  logic [4:0]  rxq [$];
  logic [3:0]  lvl = '1;
  logic        rdy = 1'b0;

  bit          mpend [NK];
  logic [1:0]  mcode [NK];
  bit          mdown [NK];
  bit          mdbl  [NK];
  bit          mlong [NK];
  int          t_dn  [NK];
  int          w_since [NK];
  int          mrr, mcount, cyc;
  bit          movf;

  key_event_ctrl #(.N_KEYS(NK), .LONG_CNT(LC), .DCLICK_CNT(DC), .FIFO_DEPTH(FD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_flag (key_flag),
    .key_value(key_value),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_code (evt_code),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      mpend[i] = 0; mcode[i] = 2'b00; mdown[i] = 0; mdbl[i] = 0; mlong[i] = 0;
      t_dn[i] = 0; w_since[i] = -1;
    end
    mrr = 0; mcount = 0; movf = 0; cyc = 0;
    sb.delete();
  endtask

  // One clock of the reference: gestures from press/release timestamps, then arbitration
  task automatic model_step();
    int         g;
    bit         pg [NK];
    logic [1:0] pc [NK];
    bit         pop, anydrop;
    cyc++;
    for (int i = 0; i < NK; i++) begin pg[i] = mpend[i]; pc[i] = mcode[i]; end
    g = -1;
    if (mcount < FD)
      for (int off = 0; off < NK; off++) begin
        int k;
        k = (mrr + off) % NK;
        if (g < 0 && pg[k]) g = k;
      end
    pop = (mcount > 0) && evt_ready;
    if (g >= 0) begin
      sb.push_back({3'(g), pc[g]});
      mpend[g] = 0;
      mrr = (g + 1) % NK;
    end
    anydrop = 0;
    for (int i = 0; i < NK; i++) begin
      logic [1:0] e;
      bit pr, rl;
      e  = 2'b00;
      pr = key_flag[i] && !key_value[i];
      rl = key_flag[i] && key_value[i];
      if (!mdown[i]) begin
        if (pr) begin
          mdown[i] = 1; t_dn[i] = cyc;
          if (w_since[i] >= 0) mdbl[i] = 1;
          w_since[i] = -1;
        end else if (w_since[i] >= 0 && cyc - w_since[i] == DC) begin
          e = 2'b01; w_since[i] = -1;
        end
      end else begin
        if (rl) begin
          mdown[i] = 0;
          if (mdbl[i]) begin e = 2'b11; mdbl[i] = 0; end
          else if (mlong[i]) mlong[i] = 0;
          else w_since[i] = cyc;
        end else if (!mdbl[i] && !mlong[i] && cyc - t_dn[i] == LC) begin
          e = 2'b10; mlong[i] = 1;
        end
      end
      if (e != 2'b00) begin
        if (pg[i] && g != i) anydrop = 1;
        else begin mpend[i] = 1; mcode[i] = e; end
      end
    end
    mcount = mcount + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    if (anydrop)      movf = 1;
    else if (ovf_clr) movf = 0;
  endtask

  task automatic tick(input logic [3:0] f, input logic clr);
    key_flag = f; key_value = lvl; evt_ready = rdy; ovf_clr = clr;
    @(posedge sys_clk);
    if (!sys_rst) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0000, 1'b0);
  endtask

  task automatic press(input logic [3:0] m);
    lvl = lvl & ~m; tick(m, 1'b0);
  endtask

  task automatic rel(input logic [3:0] m);
    lvl = lvl | m; tick(m, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; model_reset();
    tick(4'b0000, 1'b0); tick(4'b0000, 1'b0);
    sys_rst = 1'b0;
  endtask

  task automatic chk_rx1(input string nm, input logic [4:0] exp);
    chk({nm, "_count"}, 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk({nm, "_evt"}, 32'(rxq[0]), 32'(exp));
  endtask

  // Monitor: output valid/ovf against the model, head against the scoreboard on every pop
  initial begin
    logic [4:0] ex;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        chk("evt_valid", 32'(evt_valid), 32'(mcount != 0));
        chk("evt_ovf", 32'(evt_ovf), 32'(movf));
        if (evt_valid && evt_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL pop_unexpected: got %0h want none", {evt_key, evt_code});
          end else begin
            ex = sb.pop_front();
            chk("evt_head", 32'({evt_key, evt_code}), 32'(ex));
            rxq.push_back({evt_key, evt_code});
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] exp4 [5];
    logic [3:0] f;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_key", 32'(evt_key), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_ovf", 32'(evt_ovf), 32'd0);
    sys_rst = 1'b0;

    // SHORT on key1 with exact latency and hold while not ready
    rdy = 1'b0; rxq.delete();
    press(4'b0010); idle(4); rel(4'b0010); idle(10);
    chk("t1_not_early", 32'(evt_valid), 32'd0);
    idle(1);
    chk("t1_valid", 32'(evt_valid), 32'd1);
    chk("t1_head", 32'({evt_key, evt_code}), 32'({3'd1, 2'b01}));
    idle(5);
    chk("t1_hold", 32'(evt_valid), 32'd1);
    chk("t1_stable", 32'({evt_key, evt_code}), 32'({3'd1, 2'b01}));
    rdy = 1'b1; idle(3);
    chk_rx1("t1", {3'd1, 2'b01});

    // LONG on key2, release yields nothing more
    rxq.delete();
    press(4'b0100); idle(20);
    chk("t2_not_early", 32'(evt_valid), 32'd0);
    idle(1);
    chk("t2_valid", 32'(evt_valid), 32'd1);
    chk("t2_head", 32'({evt_key, evt_code}), 32'({3'd2, 2'b10}));
    idle(8); rel(4'b0100); idle(15);
    chk_rx1("t2", {3'd2, 2'b10});

    // DOUBLE on key0
    rxq.delete();
    press(4'b0001); idle(2); rel(4'b0001); idle(3); press(4'b0001); idle(2); rel(4'b0001); idle(20);
    chk_rx1("t3", {3'd0, 2'b11});

    // Release on the LONG boundary cycle -> SHORT only
    rxq.delete();
    press(4'b1000); idle(19); rel(4'b1000); idle(15);
    chk_rx1("t_bnd_long", {3'd3, 2'b01});

    // Second press on the DOUBLE timeout cycle -> DOUBLE
    rxq.delete();
    press(4'b0010); idle(2); rel(4'b0010); idle(9); press(4'b0010); idle(2); rel(4'b0010); idle(20);
    chk_rx1("t_bnd_dbl", {3'd1, 2'b11});

    // All four keys SHORT together, then overflow on key0 while FIFO full
    do_reset();
    rdy = 1'b0; rxq.delete();
    press(4'hF); idle(2); rel(4'hF); idle(15);
    chk("t4_ovf0", 32'(evt_ovf), 32'd0);
    chk("t4_head", 32'({evt_key, evt_code}), 32'({3'd0, 2'b01}));
    press(4'b0001); idle(2); rel(4'b0001); idle(11);
    chk("t4_ovf_pend", 32'(evt_ovf), 32'd0);
    press(4'b0001); idle(2); rel(4'b0001); idle(10);
    chk("t4_ovf_set", 32'(evt_ovf), 32'd1);
    tick(4'b0000, 1'b1);
    chk("t4_ovf_clr", 32'(evt_ovf), 32'd0);
    rdy = 1'b1; idle(12);
    exp4[0] = {3'd0, 2'b01}; exp4[1] = {3'd1, 2'b01}; exp4[2] = {3'd2, 2'b01};
    exp4[3] = {3'd3, 2'b01}; exp4[4] = {3'd0, 2'b01};
    chk("t4_count", 32'(rxq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rxq.size()) chk($sformatf("t4_order%0d", i), 32'(rxq[i]), 32'(exp4[i]));

    // Reset mid-gesture with queued events
    rdy = 1'b0;
    press(4'b0110); idle(2); rel(4'b0110); idle(14);
    chk("t5_queued", 32'(evt_valid), 32'd1);
    press(4'b1000); idle(5);
    #2 sys_rst = 1'b1; model_reset();
    #1 chk("t5_rst_valid", 32'(evt_valid), 32'd0);
    tick(4'b0000, 1'b0); tick(4'b0000, 1'b0);
    sys_rst = 1'b0;
    rxq.delete();
    rel(4'b1000); rdy = 1'b1; idle(40);
    chk("t5_no_events", 32'(rxq.size()), 32'd0);

    // Random gestures, spurious flags, backpressure and clears
    for (int c = 0; c < 4000; c++) begin
      f = '0;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 11) == 0) begin lvl[k] = ~lvl[k]; f[k] = 1'b1; end
        else if ($urandom_range(0, 39) == 0) f[k] = 1'b1;
      end
      rdy = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(f, 1'($urandom_range(0, 49) == 0));
    end
    rdy = 1'b1;
    if (lvl != 4'hF) rel(~lvl);
    idle(60);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
